// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
package mult_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_unit_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and the final product.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? -value : value;

endmodule

// File: rtl/mult_unit.sv
// Radix-2 shift-add MULT/MULTU unit; hi/lo and done update WIDTH+1 edges after start.
// New starts are ignored while busy; stall_req holds off HI/LO readers until done.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             read_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall_req
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH:0]     acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   shifted;

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .neg    (mult_sign & operand_a[WIDTH-1]),
        .value  (operand_a),
        .result (abs_a)
    );

    cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .neg    (mult_sign & operand_b[WIDTH-1]),
        .value  (operand_b),
        .result (abs_b)
    );

    // acc[WIDTH] is always clear by FINISH: the magnitude product fits in 2*WIDTH bits.
    cond_negate #(.WIDTH(2 * WIDTH)) u_prod (
        .neg    (neg),
        .value  ({acc[WIDTH-1:0], mplier}),
        .result (product)
    );

    always_comb begin
        sum     = acc + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
        shifted = {sum, mplier} >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        mcand  <= abs_a;
                        mplier <= abs_b;
                        neg    <= mult_sign & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= shifted[2*WIDTH:WIDTH];
                    mplier <= shifted[WIDTH-1:0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    {hi, lo} <= product;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign stall_req = busy & read_hilo;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit with a result scoreboard and latency/stall/reset checks.
module tb_mult_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start_mult;
    logic         mult_sign;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         read_hilo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall_req;

    int total;
    int bad;
    logic [2*W-1:0] sb[$];

    mult_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .read_hilo  (read_hilo),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // inject: cycle after start at which a second start is pulsed (0 = none).
    task automatic do_mult(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int inject, input bit hilo_rd,
                           input bit chk_after);
        int n;
        bit seen;
        logic [2*W-1:0] exp;
        @(negedge clk);
        mult_sign  = s;
        operand_a  = a;
        operand_b  = b;
        start_mult = 1'b1;
        read_hilo  = hilo_rd;
        sb.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (done) seen = 1'b1;
            if (inject != 0 && i == inject) begin
                start_mult = 1'b1;
                mult_sign  = ~s;
                operand_a  = 32'h1234_5678;
                operand_b  = 32'h0000_0003;
            end
            if (inject != 0 && i == inject + 1) start_mult = 1'b0;
            if (hilo_rd && i == 5) check({tag, "_stall_busy"}, 64'(stall_req), 64'd1);
        end
        if (!seen) begin
            check({tag, "_timeout"}, 64'(seen), 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(n), 64'd33);
            check({tag, "_busy_done"}, 64'(busy), 64'd0);
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            end else begin
                exp = sb.pop_front();
                check({tag, "_hi"}, 64'(hi), 64'(exp[2*W-1:W]));
                check({tag, "_lo"}, 64'(lo), 64'(exp[W-1:0]));
            end
            if (hilo_rd) check({tag, "_stall_done"}, 64'(stall_req), 64'd0);
            if (chk_after) begin
                @(posedge clk);
                #1;
                check({tag, "_done_pulse"}, 64'(done), 64'd0);
                if (hilo_rd) check({tag, "_stall_after"}, 64'(stall_req), 64'd0);
                check({tag, "_hi_hold"}, 64'(hi), 64'(exp[2*W-1:W]));
            end
        end
        read_hilo = 1'b0;
    endtask

    initial begin
        bit saw_done;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        start_mult = 1'b0;
        mult_sign  = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        read_hilo  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        read_hilo = 1'b0;

        do_mult("multu_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        // Next start lands in the done cycle of the previous multiply.
        do_mult("mult_m3x7", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0, 1'b1);
        do_mult("multu_m3x7", 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0, 1'b0);
        do_mult("mult_min_x1", 1'b1, 32'h8000_0000, 32'h0000_0001, 0, 1'b0, 1'b0);
        do_mult("mult_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 1'b0);
        do_mult("mult_neg_zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFF0, 0, 1'b0, 1'b0);
        do_mult("mult_rand", 1'b1, $urandom, $urandom, 0, 1'b0, 1'b0);
        do_mult("mult_inject", 1'b1, 32'hFFFF_FF9C, 32'h0000_0BB8, 6, 1'b1, 1'b1);
        do_mult("mult_done_start", 1'b0, 32'hDEAD_BEEF, 32'h0000_1001, 0, 1'b0, 1'b1);

        // Abort a run with reset at its tenth edge.
        @(negedge clk);
        mult_sign  = 1'b0;
        operand_a  = 32'h1234_5678;
        operand_b  = 32'h0000_0009;
        start_mult = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        do_mult("multu_5x6", 1'b0, 32'd5, 32'd6, 0, 1'b0, 1'b1);
        check("multu_5x6_lo_const", 64'(lo), 64'd30);
        check("multu_5x6_hi_const", 64'(hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
